// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers host instructions in a FIFO and issues them one per cycle,
// stalling after compute (drain), output-send (await ack) and halt opcodes.
module instr_sequencer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned PTR_W        = 3,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      instruction,
  output logic             issue_valid,
  input  logic             out_ack,
  input  logic             resume,
  output logic             busy,
  output logic             halted,
  output logic [PTR_W:0]   fifo_count
);

  typedef enum logic [1:0] {StRun, StWaitCompute, StWaitAck, StHalt} state_e;

  localparam logic [PTR_W:0] FullCount = DEPTH[PTR_W:0];
  localparam logic [7:0]     DrainInit = 8'(DRAIN_CYCLES - 1);

  localparam logic [4:0] OpCompute0 = 5'b00001;
  localparam logic [4:0] OpCompute1 = 5'b00010;
  localparam logic [4:0] OpSend     = 5'b00110;
  localparam logic [4:0] OpHalt     = 5'b11111;

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       drain_q, drain_d;
  state_e           state_q, state_d;
  logic [63:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             push, pop;
  logic [63:0]      head;

  assign in_ready    = (count_q != FullCount);
  assign push        = in_valid && in_ready;
  assign head        = mem_q[rd_ptr_q];
  assign instruction = instr_q;
  assign issue_valid = valid_q;
  assign fifo_count  = count_q;
  assign halted      = (state_q == StHalt);
  assign busy        = (state_q != StRun) || (count_q != '0);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    instr_d = '0;
    valid_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      StRun: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          instr_d = head;
          valid_d = 1'b1;
          case (head[4:0])
            OpCompute0, OpCompute1: begin
              state_d = StWaitCompute;
              drain_d = DrainInit;
            end
            OpSend:  state_d = StWaitAck;
            OpHalt:  state_d = StHalt;
            default: state_d = StRun;
          endcase
        end
      end
      StWaitCompute: begin
        if (drain_q == '0) state_d = StRun;
        else               drain_d = drain_q - 8'd1;
      end
      StWaitAck: if (out_ack) state_d = StRun;
      StHalt:    if (resume)  state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      drain_q  <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: cycle table, directed stall/halt/reset/wrap cases, then random
// traffic against a queue-based reference model.
module tb_instr_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned DRAIN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      in_instr;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      instruction;
  logic             issue_valid;
  logic             out_ack;
  logic             resume;
  logic             busy;
  logic             halted;
  logic [PTR_W:0]   fifo_count;

  int total = 0;
  int bad   = 0;

  instr_sequencer #(
    .DEPTH        (DEPTH),
    .PTR_W        (PTR_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .out_ack     (out_ack),
    .resume      (resume),
    .busy        (busy),
    .halted      (halted),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] op;
    logic       e_iv;
    int         e_src;
    logic [4:0] e_op;
    int         e_cnt;
    logic       e_busy;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [63:0] mk(input int tag, input logic [4:0] op);
    logic [31:0] t;
    t = 32'hA5A5_0000 + 32'(tag);
    return {t, 27'd0, op};
  endfunction

  function automatic vec_t v(input logic vld, input logic [4:0] op, input logic e_iv,
                             input int e_src, input logic [4:0] e_op, input int e_cnt,
                             input logic e_busy);
    vec_t r;
    r.vld = vld; r.op = op; r.e_iv = e_iv; r.e_src = e_src; r.e_op = e_op;
    r.e_cnt = e_cnt; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model state (random phase)
  logic [63:0] mq[$];
  int          m_stall;
  logic        m_wait_ack;
  logic        m_halt;

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic        acc;
    int          accepted;
    int          next_tag;
    int          steady;
    int          extra;
    logic        resumed;
    logic [63:0] got[$];
    logic [63:0] w;
    logic [63:0] exp_instr;
    logic        exp_iv;
    logic        rdy;
    int          sel;

    rst = 1'b1; in_instr = '0; in_valid = 1'b0; out_ack = 1'b0; resume = 1'b0;
    tick();
    chk("rst_instr", instruction, 64'd0);
    chk("rst_iv", 64'(issue_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back plain ops, then a compute followed by a plain op
    vecs[0]  = v(1, 5'b00100, 0, 0, 5'b0,     1, 1);
    vecs[1]  = v(1, 5'b00101, 1, 0, 5'b00100, 1, 1);
    vecs[2]  = v(1, 5'b00111, 1, 1, 5'b00101, 1, 1);
    vecs[3]  = v(0, 5'b0,     1, 2, 5'b00111, 0, 0);
    vecs[4]  = v(0, 5'b0,     0, 0, 5'b0,     0, 0);
    vecs[5]  = v(1, 5'b00001, 0, 0, 5'b0,     1, 1);
    vecs[6]  = v(1, 5'b00100, 1, 5, 5'b00001, 1, 1);
    vecs[7]  = v(0, 5'b0,     0, 0, 5'b0,     1, 1);
    vecs[8]  = v(0, 5'b0,     0, 0, 5'b0,     1, 1);
    vecs[9]  = v(0, 5'b0,     0, 0, 5'b0,     1, 1);
    vecs[10] = v(0, 5'b0,     0, 0, 5'b0,     1, 1);
    vecs[11] = v(0, 5'b0,     1, 6, 5'b00100, 0, 0);
    vecs[12] = v(0, 5'b0,     0, 0, 5'b0,     0, 0);
    for (int i = 0; i < 13; i++) begin
      in_valid = vecs[i].vld;
      in_instr = vecs[i].vld ? mk(i, vecs[i].op) : 64'd0;
      tick();
      exp_instr = vecs[i].e_iv ? mk(vecs[i].e_src, vecs[i].e_op) : 64'd0;
      chk($sformatf("vec%0d_iv", i), 64'(issue_valid), 64'(vecs[i].e_iv));
      chk($sformatf("vec%0d_instr", i), instruction, exp_instr);
      chk($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
    end
    in_valid = 1'b0;

    // Send-output waits for ack; ack during the issuing cycle is ignored
    in_valid = 1'b1; in_instr = mk(50, 5'b00110);
    tick();
    in_instr = mk(51, 5'b00011); out_ack = 1'b1;
    tick();
    chk("ack_send_iv", 64'(issue_valid), 64'd1);
    chk("ack_send_instr", instruction, mk(50, 5'b00110));
    in_valid = 1'b0; out_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("ack_wait%0d_iv", i), 64'(issue_valid), 64'd0);
      chk($sformatf("ack_wait%0d_instr", i), instruction, 64'd0);
    end
    out_ack = 1'b1;
    tick();
    chk("ack_edge_iv", 64'(issue_valid), 64'd0);
    out_ack = 1'b0;
    tick();
    chk("ack_resume_iv", 64'(issue_valid), 64'd1);
    chk("ack_resume_instr", instruction, mk(51, 5'b00011));
    tick();

    // Halt: FIFO fills while halted, then resume drains one per cycle
    in_valid = 1'b1; in_instr = mk(100, 5'b11111);
    tick();
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      in_instr = mk(201 + accepted, 5'b00100);
      acc = in_ready;
      tick();
      if (acc) accepted++;
      if (c == 0) begin
        chk("halt_word_iv", 64'(issue_valid), 64'd1);
        chk("halt_word_instr", instruction, mk(100, 5'b11111));
      end else begin
        chk($sformatf("halt_hold%0d_iv", c), 64'(issue_valid), 64'd0);
      end
    end
    chk("halt_accepted", 64'(accepted), 64'd8);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_ready", 64'(in_ready), 64'd0);
    chk("halt_count", 64'(fifo_count), 64'd8);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_halted", 64'(halted), 64'd0);
    chk("resume_count", 64'(fifo_count), 64'd8);
    chk("resume_iv", 64'(issue_valid), 64'd0);
    for (int j = 1; j <= 9; j++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      chk($sformatf("drain%0d_iv", j), 64'(issue_valid), 64'd1);
      chk($sformatf("drain%0d_instr", j), instruction, mk(200 + j, 5'b00100));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_done_count", 64'(fifo_count), 64'd0);
    chk("drain_done_iv", 64'(issue_valid), 64'd0);

    // Async reset during compute drain with 5 entries queued
    in_valid = 1'b1; in_instr = mk(60, 5'b00110);
    tick();
    in_instr = mk(61, 5'b00001);
    tick();
    for (int k = 0; k < 5; k++) begin
      in_instr = mk(62 + k, 5'b00100);
      tick();
    end
    in_valid = 1'b0; out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
    chk("pre_rst_instr", instruction, mk(61, 5'b00001));
    chk("pre_rst_count", 64'(fifo_count), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_instr", instruction, 64'd0);
    chk("arst_iv", 64'(issue_valid), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (issue_valid) extra++;
    end
    chk("arst_discarded", 64'(extra), 64'd0);

    // Full FIFO streaming across pointer wrap
    in_valid = 1'b1; in_instr = mk(300, 5'b11111);
    tick();
    next_tag = 0; steady = 0; resumed = 1'b0; got.delete();
    for (int c = 0; c < 80 && got.size() < 20; c++) begin
      in_valid = (next_tag < 20);
      in_instr = mk(400 + next_tag, 5'b00100);
      resume = !resumed && (fifo_count == 4'(DEPTH));
      if (resume) resumed = 1'b1;
      acc = in_valid && in_ready;
      tick();
      resume = 1'b0;
      if (acc) next_tag++;
      if (issue_valid && instruction[4:0] != 5'b11111) got.push_back(instruction);
      if (resumed && fifo_count == 4'(DEPTH - 1)) steady++;
    end
    in_valid = 1'b0;
    chk("wrap_count_issued", 64'(got.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("wrap_tag%0d", i), (i < got.size()) ? got[i] : 64'd0, mk(400 + i, 5'b00100));
    chk("wrap_steady", 64'(steady >= 10), 64'd1);
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (issue_valid) extra++;
    end
    chk("wrap_no_dup", 64'(extra), 64'd0);
    chk("wrap_empty", 64'(fifo_count), 64'd0);

    // Random traffic against reference model
    do_reset();
    mq.delete(); m_stall = 0; m_wait_ack = 1'b0; m_halt = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      w = {$urandom, $urandom};
      case (sel)
        0: w[4:0] = 5'b00001;
        1: w[4:0] = 5'b00010;
        2: w[4:0] = 5'b00110;
        3: w[4:0] = 5'b11111;
        default: ;
      endcase
      in_instr = w;
      out_ack  = ($urandom_range(0, 3) == 0);
      resume   = ($urandom_range(0, 3) == 0);

      rdy = (mq.size() < DEPTH);
      exp_iv = 1'b0; exp_instr = '0;
      if (m_halt) begin
        if (resume) m_halt = 1'b0;
      end else if (m_wait_ack) begin
        if (out_ack) m_wait_ack = 1'b0;
      end else if (m_stall > 0) begin
        m_stall--;
      end else if (mq.size() > 0) begin
        exp_instr = mq.pop_front();
        exp_iv = 1'b1;
        if (exp_instr[4:0] == 5'b00001 || exp_instr[4:0] == 5'b00010) m_stall = DRAIN;
        else if (exp_instr[4:0] == 5'b00110) m_wait_ack = 1'b1;
        else if (exp_instr[4:0] == 5'b11111) m_halt = 1'b1;
      end
      if (in_valid && rdy) mq.push_back(in_instr);

      tick();
      chk("rnd_iv", 64'(issue_valid), 64'(exp_iv));
      chk("rnd_instr", instruction, exp_instr);
      chk("rnd_count", 64'(fifo_count), 64'(mq.size()));
      chk("rnd_halted", 64'(halted), 64'(m_halt));
      chk("rnd_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("rnd_busy", 64'(busy), 64'(m_halt || m_wait_ack || m_stall > 0 || mq.size() > 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
